// File: rtl/isr_decoder.sv
// In-Service Register for the interrupt controller: ack sets, EOI clears, reports top level.
// Define ISR_ROTATE_ON_EOI_EN for automatic priority rotation on EOI; otherwise priority is fixed.
module isr_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ack_valid,
  input  logic [2:0] ack_level,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic [7:0] isr,
  output logic       isr_any,
  output logic [2:0] isr_top,
  output logic [2:0] low_pri,
  output logic       err
);

  logic [2:0]  start;
  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  idx;
  logic [2:0]  eoi_lvl;
  logic        eoi_err, eoi_clr, ack_err;
  logic [7:0]  after_eoi, isr_nxt;

  assign isr_any = |isr;

  // Rotate so the highest-priority level lands at bit 0, then take the first set bit.
  always_comb begin
    start = low_pri + 3'd1;
    dbl   = {isr, isr} >> start;
    rot   = dbl[7:0];
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (rot[i]) idx = 3'(i);
    isr_top = isr_any ? start + idx : 3'd0;
  end

  // EOI acts on the pre-edge ISR; the ack set is layered on top so it wins a same-bit clash.
  always_comb begin
    eoi_lvl   = eoi_specific ? eoi_level : isr_top;
    eoi_err   = eoi_valid && (eoi_specific ? !isr[eoi_level] : !isr_any);
    eoi_clr   = eoi_valid && !eoi_err;
    after_eoi = eoi_clr ? (isr & ~(8'd1 << eoi_lvl)) : isr;
    ack_err   = ack_valid && after_eoi[ack_level];
    isr_nxt   = ack_valid ? (after_eoi | (8'd1 << ack_level)) : after_eoi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr <= 8'h00;
      err <= 1'b0;
    end else begin
      isr <= isr_nxt;
      err <= eoi_err || ack_err;
    end
  end

`ifdef ISR_ROTATE_ON_EOI_EN
  logic [2:0] low_pri_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       low_pri_q <= 3'd7;
    else if (eoi_clr) low_pri_q <= eoi_lvl;
  end

  assign low_pri = low_pri_q;
`else
  assign low_pri = 3'd7;
`endif

endmodule
